uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver: oversampled start-bit qualification, 5-9 data bits LSB first,

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_rx_cfg.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receiver and the matching transmitter.
//   Contents:
//     uart_state_e   receiver FSM state encoding
//     PARITY_*       parity mode codes used by the PARITY parameter
//     clks_per_bit() system clocks per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Free-running bit-period counter 0..CLKS_PER_BIT-1 with synchronous clear.
//   Shared by the receive and transmit sides.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     clr           restart the bit period (counter loads 0 next clock)
//     sample_tick   counter == SAMPLE_AT (mid-bit sample point)
//     bit_end_tick  counter == CLKS_PER_BIT-1 (last clock of the bit period)
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SAMPLE_AT    = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic sample_tick,
    output logic bit_end_tick
);

    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP_V = CNT_W'(SAMPLE_AT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST_V)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_tick  = (cnt_q == SAMP_V);
    assign bit_end_tick = (cnt_q == LAST_V);

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver: start-bit qualification, DATA_BITS data bits
//   LSB first, optional odd/even parity, 1 or 2 stop bits, 1-entry output
//   register with valid/ready handshake and parity/framing/overrun reporting.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     rx           asynchronous serial line, idle high
//     rx_data      received word, bit 0 = first bit on the line
//     rx_valid     rx_data / rx_perr / rx_ferr hold a word
//     rx_ready     consumer accepts the word when rx_valid && rx_ready
//     rx_perr      parity mismatch of the held word
//     rx_ferr      first stop bit of the held word was low
//     overrun      1-clk pulse when a completed frame is dropped
//     busy         FSM not idle
//   Build option UART_RX_MAJORITY_EN: every bit (start bit included) is the
//   2-of-3 vote of the synchronised samples at CLKS_PER_BIT/2-1, /2, /2+1.
//   Undefined: a single sample at CLKS_PER_BIT/2.
// -----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int         CPB       = clks_per_bit(CLK_FREQ, BAUD);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the midpoint, so decide one clock later.
    localparam int         SAMPLE_AT = CPB / 2 + 1;
`else
    localparam int         SAMPLE_AT = CPB / 2;
`endif
    localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);
    localparam logic       PAR_ODD   = (PARITY == PARITY_ODD);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);

    initial begin
        if (DATA_BITS < 5 || DATA_BITS > 9) $error("uart_rx_cfg: DATA_BITS must be 5..9");
        if (PARITY < 0 || PARITY > 2)       $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        if (STOP_BITS < 1 || STOP_BITS > 2) $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        if (CPB < 8)                        $error("uart_rx_cfg: CLK_FREQ/BAUD must be >= 8");
    end

    logic                 rx_s1_q, rx_s2_q, line_d1_q;
    logic                 line;
    logic                 fall;
    uart_state_e          state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ferr_now;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 commit;
    logic                 baud_clr;
    logic                 sample_tick;
    logic                 bit_end_unused;   // wrap tick only matters to the transmitter

`ifdef UART_RX_MAJORITY_EN
    logic hist1_q, hist2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= rx_s2_q;
            hist2_q <= hist1_q;
        end
    end

    // A single-clock glitch is outvoted, so it can neither start a frame nor flip a bit.
    assign line = (rx_s2_q & hist1_q) | (rx_s2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign line = rx_s2_q;
`endif

    assign fall = line_d1_q & ~line;

    uart_baud_tick #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clr         (baud_clr),
        .sample_tick (sample_tick),
        .bit_end_tick(bit_end_unused)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ferr_now   = ferr_q;
        baud_clr   = 1'b0;
        commit     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        overrun_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    baud_clr   = 1'b1;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (sample_tick) begin
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    if (DATA_BITS > 1) begin
                        shift_d = {line, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = DATA_BITS'(line);
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_tick) begin
                    perr_d  = ((^shift_q) ^ line) != PAR_ODD;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    // Only the first stop bit can flag a framing error.
                    if (!stop_cnt_q) begin
                        ferr_now = ~line;
                    end
                    ferr_d = ferr_now;
                    if (stop_cnt_q == LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line is released so a break is one frame, not many.
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The holding register can take a new word if empty or being emptied this cycle.
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_perr_d  = perr_q;
                rx_ferr_d  = ferr_now;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            line_d1_q  <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            line_d1_q  <= line;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_perr  = rx_perr_q;
    assign rx_ferr  = rx_ferr_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Directed bench for uart_rx_cfg at 16 clocks per bit. Three instances:
//   u_8n1 (8N1), u_8e1 (8 data, even parity, 1 stop), u_5n2 (5 data, 2 stop).
//   A shared serial driver is steered to one instance at a time by sel.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    int         sel = 0;
    logic [2:0] rdy = 3'b111;

    logic       rx0, rx1, rx2;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [2:0] vld, perr, ferr, ovr, busy;
    logic [8:0] dat [3];

    assign rx0 = (sel == 0) ? rx_line : 1'b1;
    assign rx1 = (sel == 1) ? rx_line : 1'b1;
    assign rx2 = (sel == 2) ? rx_line : 1'b1;
    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {4'b0, d2};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .rx_perr(perr[0]), .rx_ferr(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));

    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .rx_perr(perr[1]), .rx_ferr(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));

    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .rx(rx2), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .rx_perr(perr[2]), .rx_ferr(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));

    // Per-instance event counters and last accepted word.
    int         acc_cnt  [3] = '{0, 0, 0};
    int         vld_cyc  [3] = '{0, 0, 0};
    int         ovr_cnt  [3] = '{0, 0, 0};
    int         busy_cyc [3] = '{0, 0, 0};
    logic [8:0] acc_data [3] = '{9'h0, 9'h0, 9'h0};
    logic       acc_perr [3] = '{1'b0, 1'b0, 1'b0};
    logic       acc_ferr [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i])  vld_cyc[i]  <= vld_cyc[i] + 1;
            if (ovr[i])  ovr_cnt[i]  <= ovr_cnt[i] + 1;
            if (busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
            if (vld[i] && rdy[i]) begin
                acc_cnt[i]  <= acc_cnt[i] + 1;
                acc_data[i] <= dat[i];
                acc_perr[i] <= perr[i];
                acc_ferr[i] <= ferr[i];
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Leaves rx_line at the last stop-bit value.
    task automatic send_frame(input int nbits, input logic [8:0] d, input bit has_par,
                              input logic par_bit, input int nstop, input logic stop1,
                              input logic stop2);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop1);
        if (nstop == 2) drive_bit(stop2);
    endtask

    int a0, v0, o0, b0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_valid", 32'(vld), 32'd0);
        check_vec("rst_busy",  32'(busy), 32'd0);
        check_vec("rst_data",  32'({d0, d1, d2}), 32'd0);
        check_vec("rst_errs",  32'({perr, ferr, ovr}), 32'd0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5
        sel = 0;
        a0 = acc_cnt[0]; v0 = vld_cyc[0]; o0 = ovr_cnt[0];
        send_frame(8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        idle(20);
        check_vec("a5_count", 32'(acc_cnt[0] - a0), 32'd1);
        check_vec("a5_data",  32'(acc_data[0]), 32'h0A5);
        check_vec("a5_perr",  32'(acc_perr[0]), 32'd0);
        check_vec("a5_ferr",  32'(acc_ferr[0]), 32'd0);
        check_vec("a5_vcyc",  32'(vld_cyc[0] - v0), 32'd1);
        check_vec("a5_ovr",   32'(ovr_cnt[0] - o0), 32'd0);
        check_vec("a5_busy",  32'(busy[0]), 32'd0);

        // 8E1 0x03: parity bit 1 is wrong for even parity, 0 is right
        sel = 1;
        a0 = acc_cnt[1];
        send_frame(8, 9'h003, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        idle(20);
        check_vec("e1_data",  32'(acc_data[1]), 32'h003);
        check_vec("e1_perr1", 32'(acc_perr[1]), 32'd1);
        send_frame(8, 9'h003, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        idle(20);
        check_vec("e1_perr0", 32'(acc_perr[1]), 32'd0);
        check_vec("e1_count", 32'(acc_cnt[1] - a0), 32'd2);

        // 8N1 0x55 with low stop bit followed by a break
        sel = 0;
        a0 = acc_cnt[0];
        send_frame(8, 9'h055, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check_vec("brk_busy_hi", 32'(busy[0]), 32'd1);
        check_vec("brk_ferr",    32'(acc_ferr[0]), 32'd1);
        check_vec("brk_data",    32'(acc_data[0]), 32'h055);
        idle(200);
        check_vec("brk_busy_lo", 32'(busy[0]), 32'd0);
        check_vec("brk_count",   32'(acc_cnt[0] - a0), 32'd1);

        // Overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        a0 = acc_cnt[0]; o0 = ovr_cnt[0];
        send_frame(8, 9'h011, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        idle(16);
        check_vec("ovr_none_yet", 32'(ovr_cnt[0] - o0), 32'd0);
        send_frame(8, 9'h022, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        idle(20);
        check_vec("ovr_hold",  32'(d0), 32'h011);
        check_vec("ovr_vld",   32'(vld[0]), 32'd1);
        check_vec("ovr_pulse", 32'(ovr_cnt[0] - o0), 32'd1);
        rdy[0] = 1'b1;
        @(negedge clk);
        check_vec("ovr_vld_fall", 32'(vld[0]), 32'd0);
        check_vec("ovr_acc",      32'(acc_data[0]), 32'h011);
        check_vec("ovr_count",    32'(acc_cnt[0] - a0), 32'd1);

        // False start: 4-clk low pulse
        a0 = acc_cnt[0]; b0 = busy_cyc[0];
        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_vec("fs_count", 32'(acc_cnt[0] - a0), 32'd0);
        check_vec("fs_seen",  32'(busy_cyc[0] != b0), 32'd1);
        check_vec("fs_idle",  32'(busy[0]), 32'd0);
`ifdef UART_RX_MAJORITY_EN
        b0 = busy_cyc[0];
        rx_line = 1'b0;
        @(negedge clk);
        idle(40);
        check_vec("glitch_busy", 32'(busy_cyc[0] - b0), 32'd0);
`endif

        // Reset during the 4th data bit of 0xFF, then a clean 0x3C
        a0 = acc_cnt[0];
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_rst_vld",  32'(vld[0]), 32'd0);
        check_vec("mid_rst_busy", 32'(busy[0]), 32'd0);
        check_vec("mid_rst_data", 32'(d0), 32'd0);
        check_vec("mid_rst_errs", 32'({perr[0], ferr[0], ovr[0]}), 32'd0);
        rst = 1'b0;
        idle(30);
        check_vec("mid_rst_nocommit", 32'(acc_cnt[0] - a0), 32'd0);
        send_frame(8, 9'h03C, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        idle(20);
        check_vec("post_rst_data",  32'(acc_data[0]), 32'h03C);
        check_vec("post_rst_count", 32'(acc_cnt[0] - a0), 32'd1);

        // 5N2: reset abort, clean 0x15, then 0x0A with low second stop bit
        sel = 2;
        a0 = acc_cnt[2];
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_vec("n2_rst_busy", 32'(busy[2]), 32'd0);
        rst = 1'b0;
        idle(30);
        send_frame(5, 9'h015, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        idle(20);
        check_vec("n2_data",  32'(acc_data[2]), 32'h015);
        check_vec("n2_ferr",  32'(acc_ferr[2]), 32'd0);
        check_vec("n2_count", 32'(acc_cnt[2] - a0), 32'd1);
        send_frame(5, 9'h00A, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        idle(40);
        check_vec("n2_stop2_data",  32'(acc_data[2]), 32'h00A);
        check_vec("n2_stop2_ferr",  32'(acc_ferr[2]), 32'd0);
        check_vec("n2_stop2_count", 32'(acc_cnt[2] - a0), 32'd2);
        check_vec("n2_stop2_busy",  32'(busy[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
